// File: rtl/fb_pkg.sv
// Shared types and sizing constants for the pixel capture framebuffer.
// Imported by the bitmap store and the capture/readout controller.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_READOUT
    } fb_state_e;

    localparam int DEF_COORD_W = 3;
    localparam int DEF_N       = 2 ** DEF_COORD_W;

    // A count of 0..N*N needs one bit more than the 2*COORD_W bits of an index.
    function automatic int cnt_width(input int coord_w);
        return 2 * coord_w + 1;
    endfunction

endpackage

// File: rtl/fb_bitmap.sv
// N x N 1-bit pixel store: set port, synchronous clear, combinational row read.
// Reports the pre-set value of the addressed bit so the parent counts only new pixels.
module fb_bitmap
    import fb_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      set_en,
    input  logic [COORD_W-1:0]        set_x,
    input  logic [COORD_W-1:0]        set_y,
    output logic                      old_bit,
    input  logic [COORD_W-1:0]        rd_idx,
    output logic [(2**COORD_W)-1:0]   rd_data
);

    localparam int N = 2 ** COORD_W;

    logic [N-1:0] bits [N];

    // NOTE: this is a flop array rather than a RAM macro, so it takes the async reset like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) bits[r] <= '0;
        end else if (clr) begin
            for (int r = 0; r < N; r++) bits[r] <= '0;
        end else if (set_en) begin
            bits[set_y][set_x] <= 1'b1;
        end
    end

    assign old_bit = bits[set_y][set_x];
    assign rd_data = bits[rd_idx];

endmodule

// File: rtl/pixel_framebuf.sv
// Capture stage for the triangle engine: accumulates pixels into a bitmap,
// counts distinct lit pixels, and scans rows out over valid/ready on completion.
module pixel_framebuf
    import fb_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      busy,
    input  logic                      po,
    input  logic [COORD_W-1:0]        xo,
    input  logic [COORD_W-1:0]        yo,
    input  logic                      clr,
    output logic                      accept_nt,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [COORD_W-1:0]        row_idx,
    output logic [(2**COORD_W)-1:0]   row_data,
    output logic                      frame_done,
    output logic [2*COORD_W:0]        pix_cnt,
    output logic                      overflow
);

    localparam int N     = 2 ** COORD_W;
    localparam int CNT_W = cnt_width(COORD_W);

    fb_state_e    state;
    logic         cap_px;
    logic         stray_px;
    logic         bm_clr;
    logic         old_bit;
    logic [N-1:0] bm_row;

    assign cap_px    = (state == ST_CAPTURE) && po;
    assign stray_px  = (state != ST_CAPTURE) && po;
    assign bm_clr    = (state == ST_IDLE) && clr;
    assign accept_nt = (state == ST_IDLE);
    // Gate with row_valid so the bus reads zero whenever no row is offered.
    assign row_data  = row_valid ? bm_row : '0;

    fb_bitmap #(.COORD_W(COORD_W)) u_bitmap (
        .clk     (clk),
        .reset   (reset),
        .clr     (bm_clr),
        .set_en  (cap_px),
        .set_x   (xo),
        .set_y   (yo),
        .old_bit (old_bit),
        .rd_idx  (row_idx),
        .rd_data (bm_row)
    );

    // NOTE: every register here uses <= so all updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            row_valid  <= 1'b0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overflow   <= stray_px | (overflow & ~bm_clr);

            if (bm_clr) begin
                pix_cnt <= '0;
            end else if (cap_px && !old_bit) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (busy) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!busy) begin
                        state     <= ST_READOUT;
                        row_valid <= 1'b1;
                        row_idx   <= '0;
                    end
                end
                ST_READOUT: begin
                    if (row_ready) begin
                        if (row_idx == '1) begin
                            state      <= ST_IDLE;
                            row_valid  <= 1'b0;
                            row_idx    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row_idx <= row_idx + COORD_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_framebuf.sv
// Scoreboard bench for pixel_framebuf: an array model predicts each scanned row,
// a negedge monitor pops and compares every accepted row and checks hold stability.
module tb_pixel_framebuf;

    localparam int CW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic          po;
    logic [CW-1:0] xo;
    logic [CW-1:0] yo;
    logic          clr;
    logic          accept_nt;
    logic          row_valid;
    logic          row_ready;
    logic [CW-1:0] row_idx;
    logic [N-1:0]  row_data;
    logic          frame_done;
    logic [2*CW:0] pix_cnt;
    logic          overflow;

    pixel_framebuf #(.COORD_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy),
        .po         (po),
        .xo         (xo),
        .yo         (yo),
        .clr        (clr),
        .accept_nt  (accept_nt),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .row_data   (row_data),
        .frame_done (frame_done),
        .pix_cnt    (pix_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [N-1:0] data;
    } row_t;

    bit   model [N][N];
    bit   model_ovf;
    row_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [N-1:0] model_row(input int y);
        logic [N-1:0] r;
        for (int x = 0; x < N; x++) r[x] = model[y][x];
        return r;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                c += int'(model[y][x]);
        return c;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                model[y][x] = 1'b0;
    endtask

    // Monitor: pops one expected row per accepted handshake; checks holds under backpressure.
    logic          mon_hold = 1'b0;
    logic [CW-1:0] mon_idx;
    logic [N-1:0]  mon_data;
    row_t          mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) begin
                    check("hold_valid", row_valid, 1);
                    check("hold_idx", row_idx, mon_idx);
                    check("hold_data", row_data, mon_data);
                end
                if (row_valid && row_ready) begin
                    if (exp_q.size() == 0) begin
                        flag_fail("unexpected_row");
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("row_idx", row_idx, mon_exp.idx);
                        check("row_data", row_data, mon_exp.data);
                    end
                end
                mon_hold = row_valid && !row_ready;
                mon_idx  = row_idx;
                mon_data = row_data;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_accept_nt"}, accept_nt, 1);
        check({tag, "_row_valid"}, row_valid, 0);
        check({tag, "_row_idx"}, row_idx, 0);
        check({tag, "_row_data"}, row_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_pix_cnt"}, pix_cnt, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_pix_cnt"}, pix_cnt, model_count());
        check({tag, "_overflow"}, overflow, model_ovf);
    endtask

    task automatic start_capture();
        busy = 1'b1;
        cyc();
        check("accept_nt_capture", accept_nt, 0);
    endtask

    task automatic send_px(input int x, input int y);
        po = 1'b1;
        xo = CW'(x);
        yo = CW'(y);
        cyc();
        po = 1'b0;
        model[y][x] = 1'b1;
    endtask

    task automatic idle_po(input int x, input int y);
        po = 1'b1;
        xo = CW'(x);
        yo = CW'(y);
        cyc();
        po = 1'b0;
        model_ovf = 1'b1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        model_clear();
        model_ovf = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready toggles starting low, 2: random ready.
    // lat counts edges from busy falling to frame_done visible, including the edge that samples busy low.
    task automatic scan(input int mode, input bit inject, output int lat);
        row_t r;
        for (int y = 0; y < N; y++) begin
            r.idx  = y;
            r.data = model_row(y);
            exp_q.push_back(r);
        end
        busy = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 300; k++) begin
            if (inject && k == 3) begin
                po = 1'b1; xo = '0; yo = '0; clr = 1'b1;
                model_ovf = 1'b1;
            end else begin
                po = 1'b0; clr = 1'b0;
            end
            case (mode)
                0:       row_ready = 1'b1;
                1:       row_ready = (k % 2 == 0);
                default: row_ready = 1'($urandom % 2);
            endcase
            cyc();
            if (frame_done) begin
                lat = k;
                break;
            end
        end
        po = 1'b0;
        clr = 1'b0;
        row_ready = 1'b0;
        if (lat < 0) flag_fail("scan_timeout");
        check("end_accept_nt", accept_nt, 1);
        check("end_row_valid", row_valid, 0);
        check("end_rows_left", exp_q.size(), 0);
        cyc();
        check("frame_done_drop", frame_done, 0);
    endtask

    int lat;
    int nrand;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; busy = 1'b0; po = 1'b0; clr = 1'b0; row_ready = 1'b0;
        xo = '0; yo = '0;
        model_clear();
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;
        cyc();

        // Single triangle
        start_capture();
        send_px(1, 1);
        send_px(2, 1);
        send_px(1, 2);
        check("single_pix_cnt", pix_cnt, 3);
        scan(0, 1'b0, lat);
        check("single_latency", lat, 9);
        check_status("single");

        // Duplicates under backpressure
        do_clr();
        check("clr_pix_cnt", pix_cnt, 0);
        start_capture();
        for (int i = 0; i < 5; i++) send_px(3, 4);
        check("dup_pix_cnt", pix_cnt, 1);
        scan(1, 1'b0, lat);
        check("backpressure_latency", lat, 16);

        // Overflow in IDLE and READOUT; clr during READOUT ignored
        do_clr();
        idle_po(0, 0);
        check("ovf_idle", overflow, 1);
        check("ovf_idle_cnt", pix_cnt, 0);
        start_capture();
        send_px(5, 6);
        scan(0, 1'b1, lat);
        check("ovf_readout", overflow, 1);
        check("clr_readout_cnt", pix_cnt, 1);
        check_status("ovf");
        do_clr();
        check("ovf_cleared", overflow, 0);
        check("ovf_clr_cnt", pix_cnt, 0);

        // Full grid, visited in a scrambled order with a few repeats
        start_capture();
        for (int i = 0; i < N * N; i++) send_px(((i * 5 + 3) % 64) % N, ((i * 5 + 3) % 64) / N);
        for (int i = 0; i < 4; i++) send_px(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
        check("full_pix_cnt", pix_cnt, 64);
        scan(0, 1'b0, lat);

        // Random frames, accumulating unless cleared
        for (int f = 0; f < 5; f++) begin
            if ($urandom % 2 == 0) do_clr();
            if ($urandom % 3 == 0) idle_po(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            start_capture();
            nrand = int'($urandom_range(0, 24));
            for (int i = 0; i < nrand; i++) begin
                if ($urandom % 4 == 0) cyc();
                send_px(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            end
            check_status("rand_capture");
            scan(2, 1'b0, lat);
            check_status("rand_after");
        end

        // Reset in the middle of a scan
        start_capture();
        send_px(6, 2);
        send_px(0, 7);
        for (int y = 0; y < N; y++) begin
            exp_q.push_back('{idx: y, data: model_row(y)});
        end
        busy = 1'b0;
        row_ready = 1'b1;
        cyc();
        for (int k = 0; k < 20 && row_idx != 3; k++) cyc();
        check("midscan_idx", row_idx, 3);
        reset = 1'b0;
        #1;
        check_reset_values("midscan");
        exp_q.delete();
        model_clear();
        model_ovf = 1'b0;
        row_ready = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("post_reset_cnt", pix_cnt, 0);
        check("post_reset_accept", accept_nt, 1);

        // Bitmap must have been wiped by the reset
        start_capture();
        send_px(7, 7);
        scan(0, 1'b0, lat);
        check_status("post_reset_frame");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
